// File: rtl/spi_periph.sv
// SPI peripheral (mode 0) with TX holding register and RX word buffer.
// Optional overrun flag output rx_ovr when SPI_PERIPH_RX_OVR_EN is defined.
module spi_periph #(
  parameter int DWIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ss_n,
  input  logic              sclk,
  input  logic              mosi,
  output logic              miso,
  input  logic [DWIDTH-1:0] tx_data,
  input  logic              tx_wr,
  output logic              tx_ready,
  output logic [DWIDTH-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_rd,
`ifdef SPI_PERIPH_RX_OVR_EN
  output logic              rx_ovr,
`endif
  output logic              busy
);

  localparam int CW = (DWIDTH > 2) ? $clog2(DWIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(DWIDTH - 1);

  typedef enum logic {
    IDLE,
    ACTIVE
  } state_t;

  state_t            r_state;
  logic              r_ss_s1, r_ss_s2;
  logic              r_sclk_s1, r_sclk_s2, r_sclk_d;
  logic              r_mosi_s1, r_mosi_s2;
  logic [DWIDTH-1:0] r_tx_hold;
  logic              r_tx_ready;
  logic [DWIDTH-1:0] r_tx_sh;
  logic [DWIDTH-2:0] r_rx_sh;
  logic [CW-1:0]     r_cnt;
  logic              r_reload;
  logic [DWIDTH-1:0] r_rx_data;
  logic              r_rx_valid;
  logic              r_rx_ovr;

  logic              w_rise;
  logic              w_fall;
  logic              w_done;
  logic [DWIDTH-1:0] w_rx_next;
  logic [DWIDTH-1:0] w_load_val;

  assign w_rise     = r_sclk_s2 & ~r_sclk_d;
  assign w_fall     = ~r_sclk_s2 & r_sclk_d;
  assign w_rx_next  = {r_rx_sh, r_mosi_s2};
  assign w_load_val = r_tx_ready ? '0 : r_tx_hold;
  assign w_done     = (r_state == ACTIVE) & r_ss_s2 == 1'b0
                    & w_rise & (r_cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ss_s1   <= 1'b1;
      r_ss_s2   <= 1'b1;
      r_sclk_s1 <= 1'b0;
      r_sclk_s2 <= 1'b0;
      r_sclk_d  <= 1'b0;
      r_mosi_s1 <= 1'b0;
      r_mosi_s2 <= 1'b0;
    end else begin
      r_ss_s1   <= ss_n;
      r_ss_s2   <= r_ss_s1;
      r_sclk_s1 <= sclk;
      r_sclk_s2 <= r_sclk_s1;
      r_sclk_d  <= r_sclk_s2;
      r_mosi_s1 <= mosi;
      r_mosi_s2 <= r_mosi_s1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_tx_hold  <= '0;
      r_tx_ready <= 1'b1;
      r_tx_sh    <= '0;
      r_rx_sh    <= '0;
      r_cnt      <= '0;
      r_reload   <= 1'b0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_rx_ovr   <= 1'b0;
    end else begin
      // tx_ready is sampled before any load this cycle
      if (tx_wr && r_tx_ready) begin
        r_tx_hold  <= tx_data;
        r_tx_ready <= 1'b0;
      end

      if (w_done) begin
        r_rx_data  <= w_rx_next;
        r_rx_valid <= 1'b1;
        if (r_rx_valid && !rx_rd)
          r_rx_ovr <= 1'b1;
        else if (rx_rd)
          r_rx_ovr <= 1'b0;
      end else if (rx_rd) begin
        r_rx_valid <= 1'b0;
        r_rx_ovr   <= 1'b0;
      end

      unique case (r_state)
        IDLE: begin
          if (!r_ss_s2) begin
            r_state  <= ACTIVE;
            r_tx_sh  <= w_load_val;
            r_rx_sh  <= '0;
            r_cnt    <= '0;
            r_reload <= 1'b0;
            if (!r_tx_ready)
              r_tx_ready <= 1'b1;
          end
        end
        ACTIVE: begin
          if (r_ss_s2) begin
            r_state  <= IDLE;
            r_tx_sh  <= '0;
            r_rx_sh  <= '0;
            r_cnt    <= '0;
            r_reload <= 1'b0;
          end else if (w_rise) begin
            r_rx_sh <= w_rx_next[DWIDTH-2:0];
            if (r_cnt == LAST) begin
              r_cnt    <= '0;
              r_reload <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end else if (w_fall) begin
            if (r_reload) begin
              r_reload <= 1'b0;
              r_tx_sh  <= w_load_val;
              if (!r_tx_ready)
                r_tx_ready <= 1'b1;
            end else begin
              r_tx_sh <= {r_tx_sh[DWIDTH-2:0], 1'b0};
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign miso     = (r_state == ACTIVE) & r_tx_sh[DWIDTH-1];
  assign busy     = (r_state == ACTIVE);
  assign tx_ready = r_tx_ready;
  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;

`ifdef SPI_PERIPH_RX_OVR_EN
  assign rx_ovr = r_rx_ovr;
`else
  logic w_unused_ovr;
  assign w_unused_ovr = r_rx_ovr;
`endif

endmodule

// File: tb/tb_spi_periph.sv
// Directed bench for spi_periph acting as a mode-0 SPI controller.
// Build with SPI_PERIPH_RX_OVR_EN to also check the overrun flag.
module tb_spi_periph;

  logic       clk = 1'b0;
  logic       rst;
  logic       ss_n;
  logic       sclk;
  logic       mosi;
  logic       miso;
  logic [7:0] tx_data;
  logic       tx_wr;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_rd;
  logic       busy;
`ifdef SPI_PERIPH_RX_OVR_EN
  logic       rx_ovr;
`endif

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] mi, mi2;

  always #5 clk = ~clk;

  spi_periph #(.DWIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .ss_n     (ss_n),
    .sclk     (sclk),
    .mosi     (mosi),
    .miso     (miso),
    .tx_data  (tx_data),
    .tx_wr    (tx_wr),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_rd    (rx_rd),
`ifdef SPI_PERIPH_RX_OVR_EN
    .rx_ovr   (rx_ovr),
`endif
    .busy     (busy)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tx_write(input logic [7:0] d);
    tx_data = d;
    tx_wr   = 1'b1;
    wclk(1);
    tx_wr   = 1'b0;
  endtask

  task automatic rx_read();
    rx_rd = 1'b1;
    wclk(1);
    rx_rd = 1'b0;
  endtask

  task automatic sel();
    ss_n = 1'b0;
    wclk(5);
  endtask

  task automatic desel();
    wclk(5);
    ss_n = 1'b1;
    wclk(5);
  endtask

  task automatic frame(input logic [7:0] mo, input int nbits,
                       output logic [7:0] mi_o);
    mi_o = '0;
    for (int i = 0; i < nbits; i++) begin
      mosi = mo[7-i];
      wclk(5);
      mi_o[7-i] = miso;
      sclk = 1'b1;
      wclk(5);
      sclk = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1; ss_n = 1'b1; sclk = 1'b0; mosi = 1'b0;
    tx_data = '0; tx_wr = 1'b0; rx_rd = 1'b0;
    wclk(3);
    rst = 1'b0;
    wclk(3);
    check("rst_tx_ready", tx_ready, 1);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_miso", miso, 0);
    check("rst_busy", busy, 0);

    tx_write(8'hA5);
    check("a5_tx_ready_lo", tx_ready, 0);
    sel();
    check("a5_busy", busy, 1);
    check("a5_tx_ready_hi", tx_ready, 1);
    frame(8'h3C, 8, mi);
    desel();
    check("a5_miso", mi, 8'hA5);
    check("a5_rx_data", rx_data, 8'h3C);
    check("a5_rx_valid", rx_valid, 1);
    check("a5_busy_lo", busy, 0);
    rx_read();
    check("a5_rd_clr", rx_valid, 0);

    sel();
    frame(8'hFF, 8, mi);
    desel();
    check("ff_miso", mi, 8'h00);
    check("ff_rx_data", rx_data, 8'hFF);
    rx_read();

    tx_write(8'h81);
    sel();
    tx_write(8'h7E);
    check("b2b_tx_ready_lo", tx_ready, 0);
    frame(8'h12, 8, mi);
    frame(8'h34, 8, mi2);
    desel();
    check("b2b_miso1", mi, 8'h81);
    check("b2b_miso2", mi2, 8'h7E);
    check("b2b_rx_data", rx_data, 8'h34);
    check("b2b_rx_valid", rx_valid, 1);
    check("b2b_tx_ready_hi", tx_ready, 1);
    check("b2b_miso_idle", miso, 0);
`ifdef SPI_PERIPH_RX_OVR_EN
    check("b2b_ovr", rx_ovr, 1);
`endif
    rx_read();
    check("b2b_rd_clr", rx_valid, 0);
`ifdef SPI_PERIPH_RX_OVR_EN
    check("b2b_ovr_clr", rx_ovr, 0);
`endif

    sel();
    frame(8'hF0, 4, mi);
    desel();
    check("part_rx_valid", rx_valid, 0);
    sel();
    frame(8'h55, 8, mi);
    desel();
    check("part_rx_data", rx_data, 8'h55);
    check("part_rx_valid2", rx_valid, 1);

    tx_write(8'hE7);
    sel();
    frame(8'hAA, 3, mi);
    sclk = 1'b1;
    wclk(2);
    rst = 1'b1; ss_n = 1'b1; sclk = 1'b0;
    wclk(1);
    check("mrst_tx_ready", tx_ready, 1);
    check("mrst_busy", busy, 0);
    check("mrst_miso", miso, 0);
    check("mrst_rx_valid", rx_valid, 0);
    check("mrst_rx_data", rx_data, 8'h00);
    rst = 1'b0;
    wclk(5);
    check("mrst_idle_busy", busy, 0);
    sel();
    frame(8'hC3, 8, mi);
    desel();
    check("mrst_rx_data2", rx_data, 8'hC3);
    check("mrst_rx_valid2", rx_valid, 1);
    check("mrst_miso2", mi, 8'h00);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/spi_periph.md
SPI_PERIPH -- requirements
Module: spi_periph

Interface
REQ-001 SHALL have parameter: DWIDTH, 8, bits per SPI frame (≥2).
REQ-002 SHALL have port: clk  in  1  system clock, all logic on rising edge.
REQ-003 SHALL have port: rst  in  1  reset; one clock, synchronous, active-high.
REQ-004 SHALL have port: ss_n  in  1  SPI select from bus, active-low, asynchronous to clk.
REQ-005 SHALL have port: sclk  in  1  SPI clock from bus (CPOL=0), asynchronous to clk.
REQ-006 SHALL have port: mosi  in  1  serial data from controller.
REQ-007 SHALL have port: miso  out  1  serial data to controller.
REQ-008 SHALL have port: tx_data  in  DWIDTH  next word to transmit.
REQ-009 SHALL have port: tx_wr  in  1  load tx_data into TX holding register.
REQ-010 SHALL have port: tx_ready  out  1  TX holding register empty.
REQ-011 SHALL have port: rx_data  out  DWIDTH  last received word.
REQ-012 SHALL have port: rx_valid  out  1  rx_data unread.
REQ-013 SHALL have port: rx_rd  in  1  consume rx_data, clears rx_valid.
REQ-014 SHALL have port: busy  out  1  frame in progress (select asserted, synchronized).

Function
REQ-015 ss_n, sclk, mosi SHALL each pass a 2-flop synchronizer; sclk edges detected from synchronized value plus one history flop.
REQ-016 Supported sclk: high and low phases each ≥4 clk cycles; behaviour outside this is undefined.
REQ-017 States: IDLE (ss_n high), ACTIVE (ss_n low); IDLE->ACTIVE on synchronized ss_n falling, ACTIVE->IDLE on synchronized ss_n rising.
REQ-018 On IDLE->ACTIVE: shift register loads TX holding register if full (tx_ready->1 same cycle), else loads all-zero; bit counter cleared.
REQ-019 miso SHALL equal shift register MSB in ACTIVE, 0 in IDLE.
REQ-020 Synchronized sclk rising edge in ACTIVE: sample synchronized mosi into rx shift register LSB-first-in (MSB first on wire), increment bit counter.
REQ-021 Synchronized sclk falling edge in ACTIVE: TX shift register shifts left one bit, zero fill.
REQ-022 On the DWIDTH-th rising edge: rx_data <= completed word, rx_valid <= 1 next clk, bit counter wraps to 0.
REQ-023 On the falling edge following a completed word, TX shift register reloads per REQ-018 instead of shifting (back-to-back frames under one ss_n).
REQ-024 tx_wr with tx_ready=1: holding register <= tx_data, tx_ready <= 0; tx_wr with tx_ready=0 ignored.
REQ-025 tx_wr in the same cycle as a holding-register load into shift register: write ignored (tx_ready sampled before load).
REQ-026 rx_rd clears rx_valid; rx_rd coincident with word completion: new word stored, rx_valid stays 1.
REQ-027 Word completing while rx_valid=1 (no rx_rd): rx_data overwritten, rx_valid stays 1.
REQ-028 ss_n deasserted mid-word: partial RX word discarded, no rx_valid, bit counter cleared, holding register unchanged.
REQ-029 busy SHALL be 1 exactly while in ACTIVE.

Reset
REQ-030 rst SHALL set: state IDLE, miso 0, tx_ready 1, rx_valid 0, rx_data 0, busy 0, shift registers 0, bit counter 0, synchronizers to idle levels (ss_n 1, sclk 0, mosi 0).
REQ-031 rst asserted mid-frame SHALL abort it; after release, block waits for a new ss_n falling edge.

Configuration
REQ-032 Macro SPI_PERIPH_RX_OVR_EN defined: output port rx_ovr (1 bit) SHALL exist; set on REQ-027 condition, sticky, cleared by rx_rd or rst.
REQ-033 Macro undefined: no rx_ovr port; overrun silent per REQ-027.

Verification
REQ-034 Reset, then idle -> tx_ready=1, rx_valid=0, miso=0, busy=0.
REQ-035 tx_wr 0xA5, ss_n low, 8 sclk cycles (half period 5 clk) with mosi 0x3C -> miso bits 1,0,1,0,0,1,0,1; rx_data=0x3C, rx_valid=1; tx_ready=1.
REQ-036 No tx_wr, one frame mosi 0xFF -> miso all 0; rx_data=0xFF.
REQ-037 Two frames under one ss_n, tx 0x81 then 0x7E written during first -> miso 0x81 then 0x7E; with macro and no rx_rd, rx_ovr=1, rx_data=second word.
REQ-038 ss_n high after 4 sclk cycles -> rx_valid stays 0; next full frame mosi 0x55 -> rx_data=0x55.
REQ-039 rst pulsed mid-frame -> all outputs at REQ-030 values next cycle; subsequent frame 0xC3 received correctly.
